nco_wavegen: RTL and testbench

Parametrised numerically controlled oscillator. It replaces the fixed 256-entry full-wave sine table in the audio path. A phase accumulator driven by a frequency control word (FCW) addresses a quarter-wave sine ROM, with quadrant-symmetry reconstruction. The block also generates square, triangle and sawtooth waveforms. Output is a signed sample stream with valid/ready backpressure, feeding the audio mixer/DAC front end.

---
 rtl/nco_wavegen.sv | 171 +++++++++++++++++
 tb/tb_nco_wavegen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nco_wavegen.sv
// nco_wavegen: numerically controlled oscillator for the audio path.
// A PHASE_W-bit phase accumulator stepped by fcw addresses a quarter-wave
// sine ROM, rebuilt over four quadrants. Square, triangle and sawtooth
// waveforms are also available. Two-stage pipeline with valid/ready output.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   enable        generate samples; phase advances only while high
//   fcw           unsigned phase increment per emitted sample
//   mode          0 sine, 1 square, 2 triangle, 3 sawtooth
//   phase_clr     synchronous accumulator clear (wins over the increment)
//   sample        signed two's-complement output sample
//   sample_valid  sample holds a valid value
//   sample_ready  consumer accepts sample
module nco_wavegen #(
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned OUT_W   = 14,
  parameter int unsigned AMP     = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [PHASE_W-1:0] fcw,
  input  logic [1:0]         mode,
  input  logic               phase_clr,
  output logic [OUT_W-1:0]   sample,
  output logic               sample_valid,
  input  logic               sample_ready
);

  localparam int unsigned Q      = 2 ** (ADDR_W - 2);
  localparam int unsigned SW     = OUT_W + 1;
  localparam int unsigned MW     = ADDR_W + OUT_W;
  localparam int unsigned AMP_SH = $clog2(AMP);
  localparam longint      ONE    = longint'(1) << 30;
  localparam longint      PI_FP  = 64'sd3373259426;  // pi * 2^30
  localparam logic signed [SW-1:0] AMP_S = SW'(AMP);
  localparam logic [ADDR_W-2:0]    Q_V   = (ADDR_W - 1)'(Q);

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SAW    = 2'd3
  } mode_e;

  // round(AMP * sin(pi/2 * i/Q)) in 2^-30 fixed point via a Taylor series,
  // evaluated only at elaboration to fill the quarter-wave table.
  function automatic logic [SW-1:0] sin_lut(input int unsigned i);
    longint x;
    longint x2;
    longint term;
    longint s_fp;
    longint v;
    x    = (longint'(i) * PI_FP) / longint'(2 * Q);
    x2   = (x * x) / ONE;
    term = x;
    s_fp = x;
    for (int unsigned n = 1; n <= 12; n++) begin
      term = -((term * x2) / ONE) / longint'((2 * n) * (2 * n + 1));
      s_fp = s_fp + term;
    end
    v = (longint'(AMP) * s_fp + ONE / 2) / ONE;
    return SW'(v);
  endfunction

  logic [SW-1:0] rom [0:Q];

  for (genvar gi = 0; gi <= Q; gi++) begin : g_rom
    localparam logic [SW-1:0] LV = sin_lut(gi);
    assign rom[gi] = LV;
  end

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               s1_valid_q;
  logic [ADDR_W-1:0]  s1_a_q;
  mode_e              s1_mode_q;
  logic [OUT_W-1:0]   sample_q;
  logic               sample_valid_q;
  logic               adv;

  assign adv = !sample_valid_q || sample_ready;

  always_comb begin
    phase_d = phase_q;
    if (phase_clr) begin
      phase_d = '0;
    end else if (adv && enable) begin
      phase_d = phase_q + fcw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_mode_q  <= MODE_SINE;
    end else if (adv) begin
      s1_valid_q <= enable;
      if (enable) begin
        s1_a_q    <= phase_q[PHASE_W-1 -: ADDR_W];
        s1_mode_q <= mode_e'(mode);
      end
    end
  end

  // Quadrant decode: idx folds the address onto the rising quarter wave.
  logic [1:0]               q;
  logic [ADDR_W-3:0]        k;
  logic [ADDR_W-2:0]        idx;
  logic signed [SW-1:0]     mag;
  logic signed [SW-1:0]     wave_w;
  logic signed [ADDR_W-1:0] saw_off;
  logic signed [MW-1:0]     saw_ext;

  assign q   = s1_a_q[ADDR_W-1 -: 2];
  assign k   = s1_a_q[ADDR_W-3:0];
  assign idx = q[0] ? (Q_V - {1'b0, k}) : {1'b0, k};

  always_comb begin
    mag     = '0;
    wave_w  = '0;
    saw_off = '0;
    saw_ext = '0;
    case (s1_mode_q)
      MODE_SINE: begin
        mag    = rom[idx];
        wave_w = q[1] ? -mag : mag;
      end
      MODE_SQUARE: begin
        wave_w = s1_a_q[ADDR_W-1] ? -AMP_S : AMP_S;
      end
      MODE_TRI: begin
        mag    = SW'((MW'(idx) << AMP_SH) >> (ADDR_W - 2));
        wave_w = q[1] ? -mag : mag;
      end
      MODE_SAW: begin
        // a - 2^(ADDR_W-1) is the address with its MSB inverted, read signed
        saw_off = {~s1_a_q[ADDR_W-1], s1_a_q[ADDR_W-2:0]};
        saw_ext = MW'(saw_off);
        wave_w  = SW'((saw_ext <<< AMP_SH) >>> (ADDR_W - 1));
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_valid_q <= 1'b0;
      sample_q       <= '0;
    end else if (adv) begin
      sample_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sample_q <= OUT_W'(wave_w);
      end
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_nco_wavegen.sv
module tb_nco_wavegen;

  localparam int  PHASE_W = 24;
  localparam int  ADDR_W  = 8;
  localparam int  OUT_W   = 14;
  localparam int  AMP     = 1024;
  localparam real PI      = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic [PHASE_W-1:0] fcw;
  logic [1:0]         mode;
  logic               phase_clr;
  logic [OUT_W-1:0]   sample;
  logic               sample_valid;
  logic               sample_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nco_wavegen #(
    .PHASE_W(PHASE_W),
    .ADDR_W (ADDR_W),
    .OUT_W  (OUT_W),
    .AMP    (AMP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .fcw         (fcw),
    .mode        (mode),
    .phase_clr   (phase_clr),
    .sample      (sample),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready)
  );

  task automatic check(input string tag, input logic signed [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference sine: round-to-nearest, symmetric about zero.
  function automatic int sine_ref(input int a);
    real v;
    v = real'(AMP) * $sin(2.0 * PI * real'(a) / 256.0);
    if (v >= 0.0) return $rtoi($floor(v + 0.5));
    return -$rtoi($floor(-v + 0.5));
  endfunction

  // Inputs change just after the rising edge; outputs are read on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next accepted sample: one shown on a falling edge with valid and ready high.
  task automatic get_sample(output int s);
    s = -99999;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (sample_valid && sample_ready) begin
        s = int'($signed(sample));
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL get_sample timeout got no_sample expected sample");
  endtask

  // Drain the pipeline, zero the phase, then stream with new settings from phase 0.
  task automatic restart(input logic [PHASE_W-1:0] f, input logic [1:0] m);
    tick();
    enable    = 1'b0;
    phase_clr = 1'b1;
    tick();
    phase_clr = 1'b0;
    repeat (2) tick();
    fcw    = f;
    mode   = m;
    enable = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int s;
  int sw [260];
  int sq_e  [4] = '{1024, 1024, -1024, -1024};
  int tri_e [4] = '{0, 1024, 0, -1024};
  int saw_e [4] = '{-1024, -512, 0, 512};
  int sw_e  [5] = '{-1024, -512, 0, -1024, 0};
  int wr_e  [5] = '{0, -1024, 0, 1024, 0};
  int clr_e [6];

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    phase_clr    = 1'b0;
    sample_ready = 1'b1;
    fcw          = 24'h010000;
    mode         = 2'd0;

    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_sample", $signed(sample), 0);

    tick();
    rst_n = 1'b1;
    tick();
    enable = 1'b1;
    @(negedge clk);
    check("lat_cyc0_valid", 32'(sample_valid), 0);
    @(negedge clk);
    check("lat_cyc1_valid", 32'(sample_valid), 0);
    @(negedge clk);
    check("lat_cyc2_valid", 32'(sample_valid), 1);
    sw[0] = int'($signed(sample));
    check("sine0", sw[0], 0);

    for (int i = 1; i < 260; i++) begin
      get_sample(sw[i]);
      check($sformatf("sine%0d", i), sw[i], sine_ref(i % 256));
    end
    check("sine_a1", sw[1], 25);
    check("sine_a2", sw[2], 50);
    check("sine_a32", sw[32], 724);
    check("sine_a64", sw[64], 1024);
    check("sine_a129", sw[129], -25);
    check("sine_a192", sw[192], -1024);
    check("sine_rep256", sw[256], 0);
    check("sine_rep257", sw[257], 25);

    // Backpressure: the sample for address 4 must hold for all stalled cycles.
    tick();
    sample_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", 32'(sample_valid), 1);
      check("stall_hold", $signed(sample), sine_ref(4));
    end
    tick();
    sample_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      get_sample(s);
      check($sformatf("resume%0d", j), s, sine_ref(4 + j));
    end

    restart(24'h400000, 2'd1);
    for (int j = 0; j < 4; j++) begin
      get_sample(s);
      check($sformatf("square%0d", j), s, sq_e[j]);
    end
    restart(24'h400000, 2'd2);
    for (int j = 0; j < 4; j++) begin
      get_sample(s);
      check($sformatf("triangle%0d", j), s, tri_e[j]);
    end
    restart(24'h400000, 2'd3);
    for (int j = 0; j < 4; j++) begin
      get_sample(s);
      check($sformatf("saw%0d", j), s, saw_e[j]);
    end
    // Saw samples for a=0 and a=64 are already loaded; sine applies from a=128.
    tick();
    mode = 2'd0;
    for (int j = 0; j < 5; j++) begin
      get_sample(s);
      check($sformatf("mode_switch%0d", j), s, sw_e[j]);
    end

    restart(24'hC00000, 2'd0);
    for (int j = 0; j < 5; j++) begin
      get_sample(s);
      check($sformatf("wrap%0d", j), s, wr_e[j]);
    end

    // Clear while streaming. The load on the clearing edge still reads the
    // old phase (address 12); the following load starts again at address 0.
    restart(24'h010000, 2'd0);
    for (int j = 0; j < 10; j++) begin
      get_sample(s);
      check($sformatf("preclr%0d", j), s, sine_ref(j));
    end
    clr_e = '{sine_ref(10), sine_ref(11), sine_ref(12), 0, 25, 50};
    tick();
    phase_clr = 1'b1;
    get_sample(s);
    check("clr0", s, clr_e[0]);
    tick();
    phase_clr = 1'b0;
    for (int j = 1; j < 6; j++) begin
      get_sample(s);
      check($sformatf("clr%0d", j), s, clr_e[j]);
    end

    // Asynchronous reset between edges while streaming.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(sample_valid), 0);
    check("arst_sample", $signed(sample), 0);
    tick();
    rst_n = 1'b1;
    get_sample(s);
    check("post_rst0", s, 0);
    get_sample(s);
    check("post_rst1", s, 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
